// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous data memory.
// One access in flight at a time: accept (IDLE) -> drive memory (ISSUE) -> respond (RESP).
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_grant;
  logic                  r_port;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  w_sel;
  logic                  w_accept;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    if (&req_valid) w_sel = ~r_last_grant;
    else            w_sel = req_valid[1];
  end

  assign w_accept = (r_state == IDLE) && (|req_valid);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (|req_valid) w_next_state = ISSUE;
      ISSUE:   w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshakes are masked while reset is held, so an aborted transaction never pulses.
  always_comb begin
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    if (rst_n) begin
      case (r_state)
        IDLE:    if (|req_valid) req_ready = w_sel ? 2'b10 : 2'b01;
        RESP:    resp_valid = r_port ? 2'b10 : 2'b01;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_sel;
      r_port       <= w_sel;
      r_mem_we     <= req_we[w_sel];
      r_mem_addr   <= w_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : req_addr[ADDR_WIDTH-1:0];
      r_mem_wdata  <= w_sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
    end else if (r_state == ISSUE) begin
      r_mem_we     <= 1'b0;
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign resp_rdata = mem_rdata;

endmodule
